lc_shreg_bank: RTL and testbench

Parametrised multi-mode register bank built from the same flop and mux resources as the logic-cell macro. It generalises the single-bit dff/dffe/dffpc cells to WIDTH bits, adding synchronous load, shift, rotate and up/down count modes with a serial chain port. It sits in the QuickLogic techlib simulation models as a technology-mapping target for wide registers, shifters and counters.

---
 rtl/lc_shreg_bank.sv | 70 +++++++
 tb/tb_lc_shreg_bank.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/lc_shreg_bank.sv
// Multi-mode register bank: a WIDTH-bit register that can load, shift, rotate and count.
// Synchronous reset, clear and preset take priority over the enabled MODE operation.
module lc_shreg_bank #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] INIT  = {WIDTH{1'b0}}
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic             EN,
    input  logic             CLR,
    input  logic             PRE,
    input  logic [2:0]       MODE,
    input  logic [WIDTH-1:0] D,
    input  logic             SI,
    output logic [WIDTH-1:0] Q,
    output logic             SO,
    output logic             TC
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    // Power-up value matches the single-bit cells, so Q is defined before the first reset edge.
    logic [WIDTH-1:0] r_q = INIT;
    logic [WIDTH-1:0] w_next;

    always_comb begin
        w_next = r_q;
        case (MODE)
            3'd1:    w_next = D;
            3'd2:    w_next = {r_q[WIDTH-2:0], SI};
            3'd3:    w_next = {SI, r_q[WIDTH-1:1]};
            3'd4:    w_next = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
            3'd5:    w_next = {r_q[0], r_q[WIDTH-1:1]};
            3'd6:    w_next = r_q + ONE;
            3'd7:    w_next = r_q - ONE;
            default: w_next = r_q;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            r_q <= INIT;
        end else if (CLR) begin
            r_q <= {WIDTH{1'b0}};
        end else if (PRE) begin
            r_q <= {WIDTH{1'b1}};
        end else if (EN) begin
            r_q <= w_next;
        end
    end

    // SO and TC ignore EN so a cascaded stage can use TC as its enable.
    always_comb begin
        SO = 1'b0;
        TC = 1'b0;
        case (MODE)
            3'd2, 3'd4: SO = r_q[WIDTH-1];
            3'd3, 3'd5: SO = r_q[0];
            3'd6:       TC = &r_q;
            3'd7:       TC = ~|r_q;
            default: begin
                SO = 1'b0;
                TC = 1'b0;
            end
        endcase
    end

    assign Q = r_q;

endmodule

// File: tb/tb_lc_shreg_bank.sv
// Bench for lc_shreg_bank: three instances (WIDTH 8, 2, 32) driven in lockstep and
// compared against an arithmetic reference model, plus directed constant checks.
module tb_lc_shreg_bank;

    logic        clk;
    logic        rstn;
    logic        en;
    logic        clr;
    logic        pre;
    logic [2:0]  mode;
    logic [31:0] d;
    logic        si;

    logic [7:0]  q8;
    logic [1:0]  q2;
    logic [31:0] q32;
    logic        so8, so2, so32;
    logic        tc8, tc2, tc32;

    int n_tests = 0;
    int n_fail  = 0;

    int          width_m [3] = '{8, 2, 32};
    longint      init_m  [3] = '{64'hA5, 64'h3, 64'hFFFF_FFFF};
    longint      q_m     [3];
    logic [31:0] q_obs   [3];
    logic        so_obs  [3];
    logic        tc_obs  [3];

    lc_shreg_bank #(.WIDTH(8), .INIT(8'hA5)) u_w8 (
        .CLK(clk), .RSTN(rstn), .EN(en), .CLR(clr), .PRE(pre), .MODE(mode),
        .D(d[7:0]), .SI(si), .Q(q8), .SO(so8), .TC(tc8)
    );
    lc_shreg_bank #(.WIDTH(2), .INIT(2'b11)) u_w2 (
        .CLK(clk), .RSTN(rstn), .EN(en), .CLR(clr), .PRE(pre), .MODE(mode),
        .D(d[1:0]), .SI(si), .Q(q2), .SO(so2), .TC(tc2)
    );
    lc_shreg_bank #(.WIDTH(32), .INIT(32'hFFFF_FFFF)) u_w32 (
        .CLK(clk), .RSTN(rstn), .EN(en), .CLR(clr), .PRE(pre), .MODE(mode),
        .D(d), .SI(si), .Q(q32), .SO(so32), .TC(tc32)
    );

    always_comb begin
        q_obs[0]  = {24'd0, q8};
        q_obs[1]  = {30'd0, q2};
        q_obs[2]  = q32;
        so_obs[0] = so8;
        so_obs[1] = so2;
        so_obs[2] = so32;
        tc_obs[0] = tc8;
        tc_obs[1] = tc2;
        tc_obs[2] = tc32;
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: plain unsigned arithmetic on a width-masked value.
    function automatic longint mask_of(input int w);
        return (longint'(1) << w) - 1;
    endfunction

    function automatic longint model_next(input int i, input longint q);
        int     w = width_m[i];
        longint m = mask_of(w);
        longint s = longint'(si);
        if (!rstn) return init_m[i];
        if (clr)   return 0;
        if (pre)   return m;
        if (!en)   return q;
        case (mode)
            3'd1:    return longint'(d) & m;
            3'd2:    return (q * 2 + s) & m;
            3'd3:    return (q / 2) + s * (longint'(1) << (w - 1));
            3'd4:    return (q * 2 + q / (longint'(1) << (w - 1))) & m;
            3'd5:    return (q / 2) + (q % 2) * (longint'(1) << (w - 1));
            3'd6:    return (q + 1) % (m + 1);
            3'd7:    return (q + m) % (m + 1);
            default: return q;
        endcase
    endfunction

    function automatic logic model_so(input int i, input longint q);
        int w = width_m[i];
        if (mode == 3'd2 || mode == 3'd4) return logic'((q >> (w - 1)) & 1);
        if (mode == 3'd3 || mode == 3'd5) return logic'(q & 1);
        return 1'b0;
    endfunction

    function automatic logic model_tc(input int i, input longint q);
        if (mode == 3'd6) return q == mask_of(width_m[i]);
        if (mode == 3'd7) return q == 0;
        return 1'b0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic r, input logic c, input logic p, input logic e,
                         input logic [2:0] m, input logic [31:0] dv, input logic s);
        rstn = r;
        clr  = c;
        pre  = p;
        en   = e;
        mode = m;
        d    = dv;
        si   = s;
    endtask

    // One clock: check SO/TC before the edge, advance the model on the edge, check Q after.
    task automatic cycle(input string tag);
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("%s_w%0d_so", tag, width_m[i]), 32'(so_obs[i]), 32'(model_so(i, q_m[i])));
            check($sformatf("%s_w%0d_tc", tag, width_m[i]), 32'(tc_obs[i]), 32'(model_tc(i, q_m[i])));
        end
        @(posedge clk);
        for (int i = 0; i < 3; i++) q_m[i] = model_next(i, q_m[i]);
        #1;
        for (int i = 0; i < 3; i++)
            check($sformatf("%s_w%0d_q", tag, width_m[i]), q_obs[i], 32'(q_m[i]));
    endtask

    initial begin
        for (int i = 0; i < 3; i++) q_m[i] = init_m[i];
        drive(1'b0, 1'b1, 1'b1, 1'b1, 3'd1, 32'h3C, 1'b0);
        #1;
        for (int i = 0; i < 3; i++)
            check($sformatf("pwrup_w%0d_q", width_m[i]), q_obs[i], 32'(init_m[i]));

        // Reset beats CLR/PRE/EN; CLR beats PRE.
        cycle("rst_prio");
        check("rst_q8_const", {24'd0, q8}, 32'hA5);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 3'd1, 32'h3C, 1'b0);
        cycle("clr_over_pre");
        check("clr_q8_const", {24'd0, q8}, 32'h00);
        drive(1'b1, 1'b0, 1'b1, 1'b1, 3'd1, 32'h3C, 1'b0);
        cycle("pre");
        check("pre_q8_const", {24'd0, q8}, 32'hFF);

        // Enable hold across all modes.
        drive(1'b1, 1'b0, 1'b0, 1'b1, 3'd1, 32'h5A, 1'b0);
        cycle("load5a");
        for (int m = 1; m <= 7; m++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, 3'(m), 32'hFFFF_FFFF, 1'b1);
            cycle($sformatf("hold_m%0d", m));
        end
        check("hold_q8_const", {24'd0, q8}, 32'h5A);

        // Shift, full shift, rotate.
        drive(1'b1, 1'b0, 1'b0, 1'b1, 3'd1, 32'h81, 1'b0);
        cycle("load81");
        drive(1'b1, 1'b0, 1'b0, 1'b1, 3'd2, 32'h0, 1'b0);
        cycle("shl");
        check("shl_q8_const", {24'd0, q8}, 32'h02);
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b1, 3'd3, 32'h0, 1'b1);
            cycle("shr_fill");
        end
        check("shr_fill_q8_const", {24'd0, q8}, 32'hFF);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 3'd1, 32'h81, 1'b0);
        cycle("load81b");
        drive(1'b1, 1'b0, 1'b0, 1'b1, 3'd4, 32'h0, 1'b0);
        cycle("rol");
        check("rol_q8_const", {24'd0, q8}, 32'h03);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 3'd1, 32'h81, 1'b0);
        cycle("load81c");
        drive(1'b1, 1'b0, 1'b0, 1'b1, 3'd5, 32'h0, 1'b0);
        cycle("ror");
        check("ror_q8_const", {24'd0, q8}, 32'hC0);

        // Count wrap both directions.
        drive(1'b1, 1'b0, 1'b0, 1'b1, 3'd1, 32'hFFFF_FFFE, 1'b0);
        cycle("loadfe");
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b1, 3'd6, 32'h0, 1'b0);
            cycle("inc_wrap");
        end
        check("inc_wrap_q8_const", {24'd0, q8}, 32'h00);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 3'd7, 32'h0, 1'b0);
        cycle("clr0");
        drive(1'b1, 1'b0, 1'b0, 1'b1, 3'd7, 32'h0, 1'b0);
        #1;
        check("dec_tc8_const", 32'(tc8), 32'h1);
        cycle("dec_wrap");
        check("dec_wrap_q8_const", {24'd0, q8}, 32'hFF);

        // Reset in the middle of a count.
        drive(1'b1, 1'b1, 1'b0, 1'b1, 3'd6, 32'h0, 1'b0);
        cycle("mid_clr");
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b1, 3'd6, 32'h0, 1'b0);
            cycle("mid_count");
        end
        drive(1'b0, 1'b0, 1'b0, 1'b1, 3'd6, 32'h0, 1'b0);
        cycle("mid_rst");
        drive(1'b1, 1'b0, 1'b0, 1'b1, 3'd6, 32'h0, 1'b0);
        cycle("mid_resume");
        check("mid_resume_q8_const", {24'd0, q8}, 32'hA6);

        // Random traffic against the model.
        for (int k = 0; k < 400; k++) begin
            drive(logic'($urandom_range(19, 0) != 0), logic'($urandom_range(9, 0) == 0),
                  logic'($urandom_range(9, 0) == 0), logic'($urandom_range(3, 0) != 0),
                  3'($urandom_range(7, 0)), $urandom, logic'($urandom_range(1, 0)));
            cycle("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
